// File: rtl/counter_3.sv
// Saturating win counter: counts 0->1 transitions of win, holding at MAX_COUNT.
// Define COUNTER3_WRAP_EN to wrap to zero after MAX_COUNT instead of saturating.
module counter_3 #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned MAX_COUNT = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             win,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  generate
    if (MAX_COUNT > (2 ** WIDTH) - 1) begin : g_bad_max
      $error("counter_3: MAX_COUNT does not fit in WIDTH bits");
    end
  endgenerate

  logic win_q;
  logic rise;

  assign rise = win & ~win_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      win_q <= 1'b0;
    end else begin
      win_q <= win;
      if (rise) begin
        if (count < MAX_C) begin
          count <= count + ONE;
        end
`ifdef COUNTER3_WRAP_EN
        else begin
          count <= '0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_counter_3.sv
// Self-checking bench for counter_3: directed scenarios plus random win/reset traffic.
module tb_counter_3;

  localparam int MAXC = 7;

  logic       clk;
  logic       reset;
  logic       win;
  logic [2:0] count;

  int errors = 0;
  int checks = 0;
  bit done   = 0;

  counter_3 #(.WIDTH(3), .MAX_COUNT(MAXC)) dut (
    .clk  (clk),
    .reset(reset),
    .win  (win),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: number of observed 0->1 transitions since reset, mapped onto the score range.
  int   rises  = 0;
  logic prev_w = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rises  = 0;
      prev_w = 1'b0;
    end else begin
      if (win === 1'b1 && prev_w === 1'b0) rises++;
      prev_w = win;
    end
  end

  function automatic int expected_score(input int r);
`ifdef COUNTER3_WRAP_EN
    return r % (MAXC + 1);
`else
    return (r > MAXC) ? MAXC : r;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: count=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      if ($isunknown(count)) begin
        checks++;
        errors++;
        $display("FAIL model: count unknown at t=%0t", $time);
      end else begin
        check("model", int'(count), expected_score(rises));
      end
    end
  end

  // Drive win for one cycle; returns at posedge+2 with the update visible.
  task automatic cyc(input logic w);
    win = w;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("async_reset", int'(count), 0);
    cyc(1'b0);
    reset = 1'b1;
    cyc(1'b0);
  endtask

  task automatic pulse();
    cyc(1'b1);
    cyc(1'b0);
  endtask

  initial begin
    reset = 1'b0;
    win   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_state", int'(count), 0);
    reset = 1'b1;
    cyc(1'b0);
    check("after_release", int'(count), 0);

    // 1: eight pulses from zero
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1);
`ifdef COUNTER3_WRAP_EN
      check("t1_step", int'(count), (i == 8) ? 0 : i);
`else
      check("t1_step", int'(count), (i == 8) ? 7 : i);
`endif
      cyc(1'b0);
    end

    // 2: reset mid-cycle discards the score, then four pulses
    #1;
    reset = 1'b0;
    #1;
    check("t2_async", int'(count), 0);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #2;
    repeat (4) pulse();
    check("t2_four", int'(count), 4);

    // 3: overdrive with ten pulses
    do_reset();
    for (int i = 1; i <= 10; i++) pulse();
`ifdef COUNTER3_WRAP_EN
    check("t3_final", int'(count), 2);
`else
    check("t3_final", int'(count), 7);
`endif

    // 4: held win counts once
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1);
      check("t4_held", int'(count), 1);
    end
    cyc(1'b0);
    check("t4_low", int'(count), 1);
    cyc(1'b1);
    check("t4_rise2", int'(count), 2);

    // 5: reset while win high, release with win still high
    do_reset();
    repeat (3) pulse();
    check("t5_three", int'(count), 3);
    win   = 1'b1;
    reset = 1'b0;
    #1;
    check("t5_async", int'(count), 0);
    cyc(1'b1);
    check("t5_in_reset", int'(count), 0);
    reset = 1'b1;
    cyc(1'b1);
    check("t5_first_edge", int'(count), 1);
    repeat (3) begin
      cyc(1'b1);
      check("t5_hold", int'(count), 1);
    end

    // 6: toggling every cycle
    do_reset();
    for (int i = 0; i < 6; i++) cyc((i % 2) == 0);
    check("t6_toggle", int'(count), 3);

    // Unknown win while reset is low
    reset = 1'b0;
    win   = 1'bx;
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    check("x_in_reset", int'(count), 0);
    win   = 1'b0;
    reset = 1'b1;
    cyc(1'b0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0;
        #1;
        check("rand_async", int'(count), 0);
        cyc(1'($urandom_range(0, 1)));
        reset = 1'b1;
      end
      cyc(1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
